pipelined_add_sub: RTL
======================

Name: pipelined_add_sub

Overview:
Parametrised, pipelined N-bit adder/subtractor for the CPU execute path. It succeeds the single-cycle ripple adder. The carry chain is split into STAGES registered segments, so wide operands close timing at high clock rates. It supports ADD/SUB/ADC/SBC, produces NZCV flags, carries a tag, and uses a valid/ready handshake with backpressure.

Parameters:
- REGISTER_WIDTH, 64, operand/result width; must be divisible by STAGES.
- STAGES, 4, number of pipeline segments (1..REGISTER_WIDTH); also the latency in cycles.
- TAG_WIDTH, 5, width of the opaque tag carried alongside each operation (e.g. destination register).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_n_i  input  1  reset, asynchronous assert, active-low.
- valid_i  input  1  operation present on the inputs.
- ready_o  output  1  block accepts an operation this cycle.
- op_i  input  2  operation (add_sub_pkg::op_e).
- A_i  input  REGISTER_WIDTH  operand A.
- B_i  input  REGISTER_WIDTH  operand B.
- carry_i  input  1  carry flag input, used by ADC/SBC only.
- tag_i  input  TAG_WIDTH  opaque tag.
- valid_o  output  1  result present.
- ready_i  input  1  consumer accepts the result.
- S_o  output  REGISTER_WIDTH  result.
- flags_o  output  4  {N,Z,C,V} (add_sub_pkg::flags_t).
- tag_o  output  TAG_WIDTH  tag of the result.

Behaviour:
- Reset: while rst_n_i=0, all stage valid bits, valid_o, S_o, flags_o, tag_o and all pipeline data are 0. ready_o=1 during and after reset. Deassertion is used synchronously; the first accept is possible on the first edge after release.
- Reset mid-operation: all in-flight operations are discarded, no partial result appears, and valid_o drops to 0 immediately (asynchronously).
- Op decode (stage 0 input):
  - ADD: B, cin=0.
  - SUB: ~B, cin=1.
  - ADC: B, cin=carry_i.
  - SBC: ~B, cin=carry_i.
- Carry convention: C=1 means no borrow on subtract.
- Segmentation: SEG=REGISTER_WIDTH/STAGES. Stage k adds bits [k*SEG +: SEG] using the carry registered from stage k-1 (cin for k=0). Upper operand slices travel forward in skew registers; lower result slices are registered forward. Each stage produces an AND-accumulated zero flag for its slice.
- Flags, computed at the final stage:
  - N = S[MSB].
  - Z = all segment zero flags.
  - C = carry out of MSB.
  - V = carry into MSB XOR carry out of MSB.
- Handshake: global advance enable en = ready_i | ~valid_o. ready_o = en.
  - An input is accepted when valid_i & ready_o.
  - When en=1, every stage shifts by one, and bubbles propagate as invalid stages.
  - When en=0, all stages hold. Internal bubbles are not collapsed.
- Latency: an op accepted at edge t appears on valid_o after edge t+STAGES-1 (visible STAGES cycles after acceptance). With continuous ready_i=1, throughput is 1 op/cycle.
- Output stability: while valid_o=1 and ready_i=0, S_o/flags_o/tag_o are held unchanged. valid_o does not drop without a handshake except on reset.
- Simultaneous accept and output handshake in the same cycle is legal; no loss or duplication.
- valid_i=1 while ready_o=0: the block does not sample the inputs; the producer holds them.
- STAGES=1: a single registered ripple stage with latency 1. Elaboration-time assertion fails if REGISTER_WIDTH % STAGES != 0 or STAGES < 1.
- Wrap-around: the sum is modulo 2^REGISTER_WIDTH; the overflow indication goes only to C/V.

Decomposition:
- add_sub_pkg holds:
  - typedef enum logic[1:0] op_e {OP_ADD=0, OP_SUB=1, OP_ADC=2, OP_SBC=3}.
  - typedef struct packed flags_t {n,z,c,v}.
  - function decode_op(op, carry) returning {invert_b, cin}.
- Sub-module add_sub_segment (combinational SEG-bit ripple slice): inputs a, b, cin; outputs sum, cout, carry-into-MSB, zero. Instantiated once per stage via generate. Pipeline registers and handshake logic live in the top.

Test Plan (REGISTER_WIDTH=64, STAGES=4 unless noted):
1. ADD A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> S=0, N=0 Z=1 C=1 V=0, valid_o exactly 4 cycles after acceptance, tag echoed.
2. SUB A=0x8000_0000_0000_0000, B=1 -> S=0x7FFF_FFFF_FFFF_FFFF, N=0 Z=0 C=1 V=1. SUB A=1, B=2 -> S=all-ones, C=0, N=1.
3. 16 back-to-back random ops, ready_i=1 -> results in order at 1/cycle, all match a reference model, tags match.
4. Backpressure: ready_i=0 for 3 cycles while valid_o=1 and valid_i=1 -> ready_o=0, outputs stable, after release all ops delivered once, in order.
5. Reset pulse (rst_n_i=0, one half-cycle) with 3 ops in flight -> valid_o=0 immediately, ready_o=1, no stale result after release, next op correct.
6. REGISTER_WIDTH=8, STAGES=1: ADC A=0x7F, B=0x00, carry_i=1 -> S=0x80, N=1 Z=0 C=0 V=1, latency 1. SBC A=0x00, B=0x00, carry_i=0 -> S=0xFF, C=0.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared types for the pipelined adder/subtractor: opcode encoding, flag layout
// and the opcode decode into an operand-B inversion plus a carry-in.
package add_sub_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_ADC = 2'd2,
      OP_SBC = 2'd3
   } op_e;

   typedef struct packed {
      logic n;
      logic z;
      logic c;
      logic v;
   } flags_t;

   typedef struct packed {
      logic invert_b;
      logic cin;
   } op_ctl_t;

   // Subtraction is A + ~B + cin, so C=1 reads as "no borrow".
   function automatic op_ctl_t decode_op(input op_e op, input logic carry);
      op_ctl_t ctl;
      ctl.invert_b = 1'b0;
      ctl.cin      = 1'b0;
      case (op)
         OP_ADD: begin ctl.invert_b = 1'b0; ctl.cin = 1'b0;  end
         OP_SUB: begin ctl.invert_b = 1'b1; ctl.cin = 1'b1;  end
         OP_ADC: begin ctl.invert_b = 1'b0; ctl.cin = carry; end
         OP_SBC: begin ctl.invert_b = 1'b1; ctl.cin = carry; end
         default: ;
      endcase
      return ctl;
   endfunction

endpackage

// File: rtl/add_sub_segment.sv
// Combinational SEG-bit ripple slice: sum, carry out, carry into the slice MSB
// (needed for signed overflow at the top slice) and a slice-zero indication.
module add_sub_segment #(
   parameter int SEG = 16
) (
   input  logic [SEG-1:0] a_i,
   input  logic [SEG-1:0] b_i,
   input  logic           cin_i,
   output logic [SEG-1:0] sum_o,
   output logic           cout_o,
   output logic           cmsb_o,
   output logic           zero_o
);

   assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};
   // sum = a ^ b ^ carry-in at every bit, so the MSB carry-in falls out directly.
   assign cmsb_o = sum_o[SEG-1] ^ a_i[SEG-1] ^ b_i[SEG-1];
   assign zero_o = ~|sum_o;

endmodule

// File: rtl/pipelined_add_sub.sv
// Pipelined N-bit add/sub: the carry chain is cut into STAGES registered slices,
// with a single global advance enable giving valid/ready backpressure.
module pipelined_add_sub
   import add_sub_pkg::*;
#(
   parameter int REGISTER_WIDTH = 64,
   parameter int STAGES         = 4,
   parameter int TAG_WIDTH      = 5
) (
   input  logic                      clk_i,
   input  logic                      rst_n_i,
   input  logic                      valid_i,
   output logic                      ready_o,
   input  op_e                       op_i,
   input  logic [REGISTER_WIDTH-1:0] A_i,
   input  logic [REGISTER_WIDTH-1:0] B_i,
   input  logic                      carry_i,
   input  logic [TAG_WIDTH-1:0]      tag_i,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [REGISTER_WIDTH-1:0] S_o,
   output flags_t                    flags_o,
   output logic [TAG_WIDTH-1:0]      tag_o
);

   localparam int SEG = (STAGES > 0) ? REGISTER_WIDTH / STAGES : 1;

   if (STAGES < 1 || (REGISTER_WIDTH % SEG) != 0 || SEG * STAGES != REGISTER_WIDTH) begin : g_cfg_check
      $error("pipelined_add_sub: REGISTER_WIDTH must be a multiple of STAGES >= 1");
   end

   logic                      en;
   op_ctl_t                   ctl;
   logic [REGISTER_WIDTH-1:0] b_eff;

   // Whole pipe moves together; bubbles are kept, not squeezed out.
   assign en      = ready_i | ~valid_o;
   assign ready_o = en;
   assign ctl     = decode_op(op_i, carry_i);
   assign b_eff   = ctl.invert_b ? ~B_i : B_i;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * SEG;
      localparam int REM = REGISTER_WIDTH - LO - SEG;

      // Operand bits from this slice upward; lower bits are already summed.
      logic [REM+SEG-1:0]   a_src, b_src;
      logic                 cin_src, zacc_src, vld_src;
      logic [TAG_WIDTH-1:0] tag_src;
      logic [SEG-1:0]       seg_sum;
      logic                 seg_cout, seg_cmsb, seg_zero;
      logic [LO+SEG-1:0]    sum_d, sum_q;
      logic                 vld_q, carry_q, zacc_q;
      logic [TAG_WIDTH-1:0] tag_q;

      if (k == 0) begin : g_first
         assign a_src    = A_i;
         assign b_src    = b_eff;
         assign cin_src  = ctl.cin;
         assign zacc_src = 1'b1;
         assign vld_src  = valid_i;
         assign tag_src  = tag_i;
         assign sum_d    = seg_sum;
      end else begin : g_next
         assign a_src    = g_stage[k-1].g_fwd.a_q;
         assign b_src    = g_stage[k-1].g_fwd.b_q;
         assign cin_src  = g_stage[k-1].carry_q;
         assign zacc_src = g_stage[k-1].zacc_q;
         assign vld_src  = g_stage[k-1].vld_q;
         assign tag_src  = g_stage[k-1].tag_q;
         assign sum_d    = {seg_sum, g_stage[k-1].sum_q};
      end

      add_sub_segment #(.SEG(SEG)) u_seg (
         .a_i    (a_src[SEG-1:0]),
         .b_i    (b_src[SEG-1:0]),
         .cin_i  (cin_src),
         .sum_o  (seg_sum),
         .cout_o (seg_cout),
         .cmsb_o (seg_cmsb),
         .zero_o (seg_zero)
      );

      always_ff @(posedge clk_i or negedge rst_n_i) begin
         if (!rst_n_i) begin
            vld_q   <= 1'b0;
            carry_q <= 1'b0;
            zacc_q  <= 1'b0;
            tag_q   <= '0;
            sum_q   <= '0;
         end else if (en) begin
            vld_q   <= vld_src;
            carry_q <= seg_cout;
            zacc_q  <= zacc_src & seg_zero;
            tag_q   <= tag_src;
            sum_q   <= sum_d;
         end
      end

      if (REM > 0) begin : g_fwd
         logic [REM-1:0] a_q, b_q;
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               a_q <= '0;
               b_q <= '0;
            end else if (en) begin
               a_q <= a_src[REM+SEG-1:SEG];
               b_q <= b_src[REM+SEG-1:SEG];
            end
         end
      end

      if (k == STAGES - 1) begin : g_last
         logic v_q;
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i)  v_q <= 1'b0;
            else if (en)   v_q <= seg_cmsb ^ seg_cout;
         end
      end
   end

   assign valid_o = g_stage[STAGES-1].vld_q;
   assign S_o     = g_stage[STAGES-1].sum_q;
   assign tag_o   = g_stage[STAGES-1].tag_q;
   assign flags_o = {S_o[REGISTER_WIDTH-1], g_stage[STAGES-1].zacc_q,
                     g_stage[STAGES-1].carry_q, g_stage[STAGES-1].g_last.v_q};

endmodule
